// File: rtl/ctrl_pipeline.sv
// ----------------------------------------------------------------------------
// ctrl_pipeline
//
// Carries the decoded WB/M/EX control bundles through the ID/EX, EX/MEM and
// MEM/WB pipeline registers and unpacks them into per-stage control strobes.
// Also owns load-use hazard detection (stall + bubble), branch flush
// (bubbles in ID/EX and EX/MEM), destination-register selection and two
// saturating event counters.
//
// Ports
//   clk, rst_n                  rising-edge clock, async active-low reset
//   WB[1:0]                     {RegWrite, MemtoReg} from decode
//   M[2:0]                      {Branch, MemRead, MemWrite} from decode
//   EX[3:0]                     {RegDst, ALUOp[1:0], ALUSrc} from decode
//   id_valid                    IF/ID holds a real instruction
//   id_rs, id_rt, id_rd         register fields of the instruction in ID
//   mem_zero                    ALU zero flag held alongside EX/MEM
//   ex_regdst/ex_aluop/ex_alusrc          ID/EX strobes
//   mem_branch/mem_read/mem_write/mem_dst EX/MEM strobes and destination
//   branch_taken                mem_branch & mem_zero
//   wb_regwrite/wb_memtoreg/wb_dst        MEM/WB strobes and destination
//   stall                       hold PC and IF/ID this cycle
//   ifid_flush                  clear IF/ID at next edge
//   stall_count, flush_count    saturating event counters
// ----------------------------------------------------------------------------
module ctrl_pipeline (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  WB,
  input  logic [2:0]  M,
  input  logic [3:0]  EX,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        mem_zero,
  output logic        ex_regdst,
  output logic        ex_alusrc,
  output logic [1:0]  ex_aluop,
  output logic        mem_branch,
  output logic        mem_read,
  output logic        mem_write,
  output logic [4:0]  mem_dst,
  output logic        branch_taken,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic [4:0]  wb_dst,
  output logic        stall,
  output logic        ifid_flush,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Sanitized decode bundle
  logic [1:0] id_wb;
  logic [3:0] id_ex;
  logic [4:0] id_rd_clean;

  // ID/EX stage
  logic [1:0] idex_wb;
  logic [2:0] idex_m;
  logic [3:0] idex_ex;
  logic [4:0] idex_rt;
  logic [4:0] idex_rd;

  // EX/MEM stage
  logic [1:0] exmem_wb;
  logic [2:0] exmem_m;
  logic [4:0] exmem_dst;

  // MEM/WB stage
  logic [1:0] memwb_wb;
  logic [4:0] memwb_dst;

  // Counters
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Hazard / flush control
  logic       taken;
  logic       rt_match;
  logic       load_use;
  logic       stall_int;
  logic       idex_bubble;
  logic [4:0] ex_dst;

  // Decode leaves MemtoReg, RegDst and the rd field as don't-cares whenever
  // RegWrite is low (stores, branches). Replace them with zeros here so no X
  // can ever reach the later stages or the outputs.
  always_comb begin
    id_wb       = 2'b00;
    id_ex       = {1'b0, EX[2:0]};
    id_rd_clean = 5'd0;
    if (WB[1]) begin
      id_wb       = WB;
      id_ex       = EX;
      id_rd_clean = id_rd;
    end
  end

  // A taken branch is resolved from the EX/MEM contents.
  assign taken = exmem_m[2] & mem_zero;

  // Load-use: the load sitting in ID/EX writes a register that the
  // instruction in ID reads. $0 never creates a dependency. A taken branch
  // discards the younger load, so it suppresses the stall.
  always_comb begin
    rt_match  = (idex_rt == id_rs) || (idex_rt == id_rt);
    load_use  = idex_m[1] && (idex_rt != 5'd0) && id_valid && rt_match;
    stall_int = load_use && !taken;
  end

  assign idex_bubble = stall_int | taken | ~id_valid;

  // Destination resolution; idex_rd is already zero when RegWrite is low.
  always_comb begin
    ex_dst = 5'd0;
    if (idex_wb[1]) begin
      ex_dst = idex_ex[3] ? idex_rd : idex_rt;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_wb <= 2'b00;
      idex_m  <= 3'b000;
      idex_ex <= 4'b0000;
      idex_rt <= 5'd0;
      idex_rd <= 5'd0;
    end else if (idex_bubble) begin
      idex_wb <= 2'b00;
      idex_m  <= 3'b000;
      idex_ex <= 4'b0000;
      idex_rt <= 5'd0;
      idex_rd <= 5'd0;
    end else begin
      idex_wb <= id_wb;
      idex_m  <= M;
      idex_ex <= id_ex;
      idex_rt <= id_rt;
      idex_rd <= id_rd_clean;
    end
  end

  // EX/MEM register; the instruction behind a taken branch is squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_wb  <= 2'b00;
      exmem_m   <= 3'b000;
      exmem_dst <= 5'd0;
    end else if (taken) begin
      exmem_wb  <= 2'b00;
      exmem_m   <= 3'b000;
      exmem_dst <= 5'd0;
    end else begin
      exmem_wb  <= idex_wb;
      exmem_m   <= idex_m;
      exmem_dst <= ex_dst;
    end
  end

  // MEM/WB register; the branch itself moves on (RegWrite=0 so harmless).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_wb  <= 2'b00;
      memwb_dst <= 5'd0;
    end else begin
      memwb_wb  <= exmem_wb;
      memwb_dst <= exmem_dst;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_int && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (taken && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

  assign ex_regdst    = idex_ex[3];
  assign ex_aluop     = idex_ex[2:1];
  assign ex_alusrc    = idex_ex[0];

  assign mem_branch   = exmem_m[2];
  assign mem_read     = exmem_m[1];
  assign mem_write    = exmem_m[0];
  assign mem_dst      = exmem_dst;
  assign branch_taken = taken;

  assign wb_regwrite  = memwb_wb[1];
  assign wb_memtoreg  = memwb_wb[0];
  assign wb_dst       = memwb_dst;

  assign stall        = stall_int;
  assign ifid_flush   = taken;
  assign stall_count  = stall_cnt;
  assign flush_count  = flush_cnt;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// ----------------------------------------------------------------------------
// tb_ctrl_pipeline
//
// Self-checking bench for ctrl_pipeline: a table of hazard-free bundles whose
// expected per-stage outputs are pushed to a scoreboard when driven and
// popped at the stage latency, plus hand-written sequences for load-use,
// store don't-cares, branch flush, mid-stream reset and counter saturation.
// ----------------------------------------------------------------------------
module tb_ctrl_pipeline;

  logic        clk;
  logic        rst_n;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [3:0]  EX;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        mem_zero;
  logic        ex_regdst, ex_alusrc;
  logic [1:0]  ex_aluop;
  logic        mem_branch, mem_read, mem_write;
  logic [4:0]  mem_dst;
  logic        branch_taken;
  logic        wb_regwrite, wb_memtoreg;
  logic [4:0]  wb_dst;
  logic        stall, ifid_flush;
  logic [15:0] stall_count, flush_count;

  ctrl_pipeline dut (
    .clk(clk), .rst_n(rst_n), .WB(WB), .M(M), .EX(EX), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .mem_branch(mem_branch), .mem_read(mem_read), .mem_write(mem_write),
    .mem_dst(mem_dst), .branch_taken(branch_taken),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_dst(wb_dst),
    .stall(stall), .ifid_flush(ifid_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
    logic [4:0] rs, rt, rd;
    logic [3:0] exp_ex;
    logic [4:0] exp_dst;
    logic [1:0] exp_wb;
  } vec_t;

  typedef struct {
    int   due;
    int   idx;
    vec_t v;
  } sb_t;

  vec_t vecs[12];
  sb_t  exq[$];
  sb_t  memq[$];
  sb_t  wbq[$];

  int n_vec  = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic [1:0] wb, logic [2:0] m, logic [3:0] ex,
                              logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                              logic [3:0] exp_ex, logic [4:0] exp_dst,
                              logic [1:0] exp_wb);
    vec_t v;
    v.wb = wb; v.m = m; v.ex = ex;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.exp_ex = exp_ex; v.exp_dst = exp_dst; v.exp_wb = exp_wb;
    return v;
  endfunction

  function automatic logic [63:0] allOut();
    return {10'd0, ex_regdst, ex_aluop, ex_alusrc, mem_branch, mem_read,
            mem_write, mem_dst, branch_taken, wb_regwrite, wb_memtoreg,
            wb_dst, stall, ifid_flush, stall_count, flush_count};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    id_valid = 1'b1;
    WB = v.wb; M = v.m; EX = v.ex;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
  endtask

  task automatic idle();
    id_valid = 1'b0;
    WB = 2'b00; M = 3'b000; EX = 4'b0000;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] m,
                       input logic [3:0] ex, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    applyStimulus(mk(wb, m, ex, rs, rt, rd, 4'd0, 5'd0, 2'd0));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drainScoreboard(input int n);
    sb_t s;
    while (exq.size() > 0 && exq[0].due <= n) begin
      s = exq.pop_front();
      checkOutput($sformatf("vec%0d_ex", s.idx),
                  64'({ex_regdst, ex_aluop, ex_alusrc}), 64'(s.v.exp_ex));
    end
    while (memq.size() > 0 && memq[0].due <= n) begin
      s = memq.pop_front();
      checkOutput($sformatf("vec%0d_mem", s.idx),
                  64'({mem_branch, mem_read, mem_write, mem_dst}),
                  64'({s.v.m, s.v.exp_dst}));
    end
    while (wbq.size() > 0 && wbq[0].due <= n) begin
      s = wbq.pop_front();
      checkOutput($sformatf("vec%0d_wb", s.idx),
                  64'({wb_regwrite, wb_memtoreg, wb_dst}),
                  64'({s.v.exp_wb, s.v.exp_dst}));
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sb_t s;

    // {wb, m, ex, rs, rt, rd, exp {regdst,aluop,alusrc}, exp dst, exp wb}
    vecs[0]  = mk(2'b10, 3'b000, 4'b1100, 5'd1, 5'd3,  5'd5,  4'b1100, 5'd5,  2'b10);
    vecs[1]  = mk(2'b11, 3'b010, 4'b0001, 5'd2, 5'd8,  5'd0,  4'b0001, 5'd8,  2'b11);
    vecs[2]  = mk(2'b10, 3'b000, 4'b0001, 5'd4, 5'd9,  5'd7,  4'b0001, 5'd9,  2'b10);
    vecs[3]  = mk(2'b00, 3'b001, 4'b0001, 5'd4, 5'd6,  5'd12, 4'b0001, 5'd0,  2'b00);
    vecs[4]  = mk(2'b00, 3'b100, 4'b0010, 5'd1, 5'd2,  5'd3,  4'b0010, 5'd0,  2'b00);
    vecs[5]  = mk(2'b10, 3'b000, 4'b1100, 5'd5, 5'd6,  5'd31, 4'b1100, 5'd31, 2'b10);
    vecs[6]  = mk(2'b00, 3'b000, 4'b1100, 5'd7, 5'd8,  5'd9,  4'b0100, 5'd0,  2'b00);
    vecs[7]  = mk(2'b01, 3'b000, 4'b0000, 5'd1, 5'd1,  5'd1,  4'b0000, 5'd0,  2'b00);
    vecs[8]  = mk(2'b11, 3'b010, 4'b0001, 5'd3, 5'd0,  5'd0,  4'b0001, 5'd0,  2'b11);
    vecs[9]  = mk(2'b10, 3'b000, 4'b1100, 5'd0, 5'd0,  5'd4,  4'b1100, 5'd4,  2'b10);
    vecs[10] = mk(2'b10, 3'b000, 4'b1101, 5'd2, 5'd3,  5'd17, 4'b1101, 5'd17, 2'b10);
    vecs[11] = mk(2'b10, 3'b000, 4'b0011, 5'd3, 5'd21, 5'd0,  4'b0011, 5'd21, 2'b10);

    rst_n = 1'b0;
    mem_zero = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("reset_all_zero", allOut(), 64'd0);
    rst_n = 1'b1;

    // Table-driven stream through the scoreboard
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        applyStimulus(vecs[i]);
        s.idx = i; s.v = vecs[i];
        s.due = i;     exq.push_back(s);
        s.due = i + 1; memq.push_back(s);
        s.due = i + 2; wbq.push_back(s);
      end else begin
        idle();
      end
      #1;
      checkOutput($sformatf("tab%0d_stall", i), 64'(stall), 64'd0);
      checkOutput($sformatf("tab%0d_taken", i), 64'(branch_taken), 64'd0);
      tick();
      drainScoreboard(i);
    end
    checkOutput("sb_empty", 64'(exq.size() + memq.size() + wbq.size()), 64'd0);

    // Load-use: lw $8 then a reader of $8
    drive(2'b11, 3'b010, 4'b0001, 5'd1, 5'd8, 5'd0);
    tick();
    drive(2'b10, 3'b000, 4'b1100, 5'd8, 5'd2, 5'd10);
    #1;
    checkOutput("lu_stall", 64'(stall), 64'd1);
    tick();
    checkOutput("lu_bubble_ex", 64'({ex_regdst, ex_aluop, ex_alusrc}), 64'd0);
    checkOutput("lu_one_cycle", 64'(stall), 64'd0);
    checkOutput("lu_mem_read", 64'(mem_read), 64'd1);
    checkOutput("lu_stall_count", 64'(stall_count), 64'd1);
    tick();
    checkOutput("lu_wb", 64'({wb_regwrite, wb_memtoreg, wb_dst}), 64'({2'b11, 5'd8}));
    checkOutput("lu_use_ex", 64'({ex_regdst, ex_aluop, ex_alusrc}), 64'b1100);
    idle();
    tick();
    tick();

    // Store with don't-care bits from decode
    id_valid = 1'b1;
    WB = 2'b0x; M = 3'b001; EX = 4'bx001;
    id_rs = 5'd3; id_rt = 5'd7; id_rd = 5'bxxxxx;
    tick();
    checkOutput("st_ex", 64'({ex_regdst, ex_aluop, ex_alusrc}), 64'b0001);
    checkOutput("st_nox_ex", 64'($isunknown(allOut())), 64'd0);
    idle();
    tick();
    checkOutput("st_mem", 64'({mem_write, mem_dst}), 64'({1'b1, 5'd0}));
    tick();
    checkOutput("st_wb", 64'({wb_regwrite, wb_memtoreg, wb_dst}), 64'd0);
    checkOutput("st_nox_wb", 64'($isunknown(allOut())), 64'd0);
    tick();

    // Taken beq in EX/MEM while lw (ID/EX) -> use (ID) hazard is present
    drive(2'b00, 3'b100, 4'b0010, 5'd1, 5'd2, 5'd0);
    tick();
    drive(2'b11, 3'b010, 4'b0001, 5'd3, 5'd8, 5'd0);
    tick();
    drive(2'b10, 3'b000, 4'b1100, 5'd8, 5'd4, 5'd9);
    mem_zero = 1'b1;
    #1;
    checkOutput("br_taken", 64'({branch_taken, ifid_flush, mem_branch}), 64'b111);
    checkOutput("br_stall_off", 64'(stall), 64'd0);
    tick();
    mem_zero = 1'b0;
    checkOutput("br_ex_bubble", 64'({ex_regdst, ex_aluop, ex_alusrc}), 64'd0);
    checkOutput("br_mem_bubble", 64'({mem_branch, mem_read, mem_write, mem_dst}), 64'd0);
    checkOutput("br_flush_count", 64'(flush_count), 64'd1);
    checkOutput("br_stall_count", 64'(stall_count), 64'd1);
    checkOutput("br_wb_nowrite", 64'(wb_regwrite), 64'd0);
    idle();
    tick();
    tick();

    // Reset in the middle of a stream
    drive(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd5);
    tick();
    drive(2'b11, 3'b010, 4'b0001, 5'd1, 5'd8, 5'd0);
    tick();
    drive(2'b10, 3'b000, 4'b1100, 5'd8, 5'd3, 5'd6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_all_zero", allOut(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b10, 3'b000, 4'b1100, 5'd2, 5'd1, 5'd6);
    tick();
    checkOutput("rst_resume_ex", 64'({ex_regdst, ex_aluop, ex_alusrc}), 64'b1100);
    checkOutput("rst_discard_mem", 64'({mem_branch, mem_read, mem_write, mem_dst}), 64'd0);
    checkOutput("rst_discard_wb", 64'({wb_regwrite, wb_memtoreg, wb_dst}), 64'd0);
    checkOutput("rst_counters", 64'({stall_count, flush_count}), 64'd0);
    idle();
    tick();
    tick();

    // Saturation, starting from preloaded counter values
    force dut.stall_cnt = 16'hFFFD;
    force dut.flush_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    release dut.flush_cnt;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 3'b010, 4'b0001, 5'd8, 5'd8, 5'd0);
      tick();
      tick();
      checkOutput($sformatf("sat_stall%0d", k), 64'(stall_count),
                  (k == 0) ? 64'hFFFE : 64'hFFFF);
    end
    idle();
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(2'b00, 3'b100, 4'b0010, 5'd1, 5'd2, 5'd0);
      tick();
      idle();
      tick();
      mem_zero = 1'b1;
      tick();
      mem_zero = 1'b0;
      checkOutput($sformatf("sat_flush%0d", k), 64'(flush_count), 64'hFFFF);
    end
    checkOutput("sat_stall_hold", 64'(stall_count), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
